layernorm_row_serializer: RTL

//   Downstream end of the layernorm result interface. Accepts one normalized sentence row
//   (INPUT_NUM elements, flat bus, active-low valid) and streams it to the memory/next-op

---
 rtl/layernorm_pkg.sv | 24 ++
 rtl/layernorm_row_buffer.sv | 37 +++
 rtl/layernorm_row_serializer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/layernorm_pkg.sv
// Shared types and helpers for the layernorm row serializer.
// Holds the FSM state enum, default geometry and width helpers.
package layernorm_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ln_state_t;

    localparam int LN_OUTPUT_WIDTH = 8;
    localparam int LN_INPUT_NUM    = 768;
    localparam int LN_LANES        = 16;
    localparam int LN_SENTENCE_NUM = 128;

    function automatic int ln_beats(input int input_num, input int lanes);
        return input_num / lanes;
    endfunction

    // Counter width that stays at least 1 bit when the count collapses to one value.
    function automatic int ln_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layernorm_row_buffer.sv
// One row register with parallel load and shift-right-by-one-beat.
// O_W selects how many low bits are exposed (one beat, or the whole row).
module layernorm_row_buffer
    import layernorm_pkg::*;
#(
    parameter int OUTPUT_WIDTH = LN_OUTPUT_WIDTH,
    parameter int INPUT_NUM    = LN_INPUT_NUM,
    parameter int LANES        = LN_LANES,
    parameter int O_W          = LN_LANES * LN_OUTPUT_WIDTH
) (
    input  logic                              clk_p,
    input  logic                              rst_p,
    input  logic                              i_load,
    input  logic [OUTPUT_WIDTH*INPUT_NUM-1:0] i_load_data,
    input  logic                              i_shift,
    output logic [O_W-1:0]                    o_out
);

    localparam int ROW_W   = OUTPUT_WIDTH * INPUT_NUM;
    localparam int SHIFT_W = OUTPUT_WIDTH * LANES;

    logic [ROW_W-1:0] r_row;

    // Load wins over shift so a new row can replace the last beat in the same edge.
    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            r_row <= '0;
        end else if (i_load) begin
            r_row <= i_load_data;
        end else if (i_shift) begin
            r_row <= r_row >> SHIFT_W;
        end
    end

    assign o_out = r_row[O_W-1:0];

endmodule

// File: rtl/layernorm_row_serializer.sv
// Streams one captured layernorm row as LANES-element beats with row/frame markers.
// Define LN_SER_DBUF_EN to add a shadow row buffer for zero-bubble row-to-row streaming.
module layernorm_row_serializer
    import layernorm_pkg::*;
#(
    parameter int OUTPUT_WIDTH = LN_OUTPUT_WIDTH,
    parameter int INPUT_NUM    = LN_INPUT_NUM,
    parameter int LANES        = LN_LANES,
    parameter int SENTENCE_NUM = LN_SENTENCE_NUM,
    localparam int ROW_W  = OUTPUT_WIDTH * INPUT_NUM,
    localparam int BEAT_W = LANES * OUTPUT_WIDTH,
    localparam int BEATS  = ln_beats(INPUT_NUM, LANES),
    localparam int CNT_W  = ln_cnt_w(BEATS),
    localparam int IDX_W  = ln_cnt_w(SENTENCE_NUM)
) (
    input  logic              clk_p,
    input  logic              rst_p,
    input  logic [ROW_W-1:0]  row,
    input  logic              row_valid_n,
    output logic              row_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              out_eof,
    output logic [IDX_W-1:0]  row_idx
);

    ln_state_t        r_state;
    ln_state_t        w_state_next;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [IDX_W-1:0] r_row_idx;

    logic             w_accept;
    logic             w_fire;
    logic             w_last_beat;
    logic             w_last_fire;
    logic             w_row_continue;
    logic             w_active_load;
    logic [ROW_W-1:0] w_active_data;

    assign out_valid   = (r_state == STREAM);
    assign w_accept    = !row_valid_n && row_ready;
    assign w_fire      = out_valid && out_ready;
    assign w_last_beat = (r_beat_cnt == CNT_W'(BEATS - 1));
    assign w_last_fire = w_fire && w_last_beat;

`ifdef LN_SER_DBUF_EN
    logic             r_shadow_full;
    logic             w_shadow_load;
    logic [ROW_W-1:0] w_shadow_row;

    // A row arriving on the last-beat edge with an empty shadow goes straight to the active buffer.
    assign w_shadow_load  = w_accept && (r_state == STREAM) && !w_last_fire;
    assign w_active_load  = (w_accept && ((r_state == IDLE) || w_last_fire))
                          || (w_last_fire && r_shadow_full);
    assign w_active_data  = (w_last_fire && r_shadow_full) ? w_shadow_row : row;
    assign w_row_continue = r_shadow_full || w_accept;
    assign row_ready      = !r_shadow_full;

    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            r_shadow_full <= 1'b0;
        end else if (w_shadow_load) begin
            r_shadow_full <= 1'b1;
        end else if (w_last_fire) begin
            r_shadow_full <= 1'b0;
        end
    end

    layernorm_row_buffer #(
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .INPUT_NUM    (INPUT_NUM),
        .LANES        (LANES),
        .O_W          (ROW_W)
    ) u_shadow_buf (
        .clk_p       (clk_p),
        .rst_p       (rst_p),
        .i_load      (w_shadow_load),
        .i_load_data (row),
        .i_shift     (1'b0),
        .o_out       (w_shadow_row)
    );
`else
    assign w_active_load  = w_accept;
    assign w_active_data  = row;
    assign w_row_continue = 1'b0;
    assign row_ready      = (r_state == IDLE);
`endif

    layernorm_row_buffer #(
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .INPUT_NUM    (INPUT_NUM),
        .LANES        (LANES),
        .O_W          (BEAT_W)
    ) u_active_buf (
        .clk_p       (clk_p),
        .rst_p       (rst_p),
        .i_load      (w_active_load),
        .i_load_data (w_active_data),
        .i_shift     (w_fire),
        .o_out       (out_data)
    );

    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:   if (w_accept) w_state_next = STREAM;
            STREAM: if (w_last_fire && !w_row_continue) w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            r_beat_cnt <= '0;
            r_row_idx  <= '0;
        end else if (w_fire) begin
            if (w_last_beat) begin
                r_beat_cnt <= '0;
                r_row_idx  <= (r_row_idx == IDX_W'(SENTENCE_NUM - 1)) ? '0 : r_row_idx + 1'b1;
            end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    assign out_last = out_valid && w_last_beat;
    assign out_eof  = out_last && (r_row_idx == IDX_W'(SENTENCE_NUM - 1));
    assign row_idx  = r_row_idx;

endmodule
